// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampled UART receiver with majority voting and a valid/ready holding register
// Frame: start, 8 data LSB first, optional even parity, stop; errors reported as one-cycle pulses.
module uart_rx_ovs #(
  parameter int CLKS_PER_BIT = 20,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LO  = CW'(H - 1);
  localparam logic [CW-1:0] C_MID = CW'(H);
  localparam logic [CW-1:0] C_HI  = CW'(H + 1);
  localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          s0, s1, par_bit;
  logic [7:0]    shreg;
  logic          m, at_mid, at_end;

  // Majority of the two stored samples and the live third sample.
  assign m      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign at_mid = (cnt == C_HI);
  assign at_end = (cnt == C_END);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      par_bit    <= 1'b0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      rx_s       <= sync1;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      cnt        <= cnt + 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (cnt == C_LO)  s0 <= rx_s;
      if (cnt == C_MID) s1 <= rx_s;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (at_mid && m) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (at_mid) shreg <= {m, shreg[7:1]};
          if (at_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (at_mid) par_bit <= m;
          if (at_end) begin
            state <= STOP;
            cnt   <= '0;
          end
        end
        STOP: begin
          // Resolved mid-bit so the next start edge can be caught without a gap.
          if (at_mid) begin
            cnt <= '0;
            if (!m) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else if ((PARITY_EN != 0) && (^{shreg, par_bit})) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - randomized self-checking bench for uart_rx_ovs
`timescale 1ns/1ps
module tb_uart_rx_ovs;
  localparam int CPB = 20;
  localparam int H   = CPB / 2;
  localparam int LAT = 9 * CPB + H + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0_o, fe1_o, pe0_o, pe1_o, ov0_o, ov1_o, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ovs #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx0), .rx_data(data0), .rx_valid(valid0),
    .rx_ready(ready0), .frame_err(fe0_o), .parity_err(pe0_o), .overrun(ov0_o), .busy(busy0));

  uart_rx_ovs #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx1), .rx_data(data1), .rx_valid(valid1),
    .rx_ready(ready1), .frame_err(fe1_o), .parity_err(pe1_o), .overrun(ov1_o), .busy(busy1));

  // Consumer side: record every accepted byte and every error pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid0 && ready0) got0.push_back(data0);
      if (valid1 && ready1) got1.push_back(data1);
      if (fe0_o) fe0 <= fe0 + 1;
      if (pe0_o) pe0 <= pe0 + 1;
      if (ov0_o) ov0 <= ov0 + 1;
      if (fe1_o) fe1 <= fe1 + 1;
      if (pe1_o) pe1 <= pe1 + 1;
      if (ov1_o) ov1 <= ov1 + 1;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_line(which, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // pmode: 0 = no parity bit, 1 = correct even parity, 2 = inverted parity
  task automatic send_frame(input int which, input logic [7:0] b, input int pmode, input logic stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i]);
    if (pmode == 1) drive_bit(which, ^b);
    else if (pmode == 2) drive_bit(which, ~^b);
    drive_bit(which, stop);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, base, gap;
    logic [7:0] b;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(5);
    check("reset_valid", int'(valid0), 0);
    check("reset_data", int'(data0), 0);
    check("reset_busy", int'(busy0), 0);

    // Single frame latency and one-cycle valid with ready held high
    e0 = cyc + 1;
    fork
      send_frame(0, 8'hA5, 0, 1'b1);
      begin
        wait_cyc(e0 + LAT - 1);
        check("lat_before", int'(valid0), 0);
        wait_cyc(e0 + LAT);
        check("lat_rise", int'(valid0), 1);
        check("lat_data", int'(data0), 'hA5);
        wait_cyc(e0 + LAT + 1);
        check("valid_one_cycle", int'(valid0), 0);
      end
    join
    check("a5_count", got0.size(), 1);
    check("a5_byte", (got0.size() > 0) ? int'(got0[0]) : -1, 'hA5);
    got0.delete();

    // Reset asserted in the middle of data bit 3
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    rx0 = 1'b1;
    idle(H);
    check("mid_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid0), 0);
    check("mid_rst_data", int'(data0), 0);
    check("mid_rst_busy", int'(busy0), 0);
    check("mid_rst_pulses", int'({fe0_o, pe0_o, ov0_o}), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3 * CPB);
    send_frame(0, 8'h3C, 0, 1'b1);
    idle(5);
    check("after_rst_count", got0.size(), 1);
    check("after_rst_byte", (got0.size() > 0) ? int'(got0[0]) : -1, 'h3C);
    got0.delete();

    // Short glitch on the line
    base = fe0;
    rx0 = 1'b0;
    idle(5);
    rx0 = 1'b1;
    idle(2 * CPB);
    check("glitch_busy", int'(busy0), 0);
    check("glitch_no_byte", got0.size(), 0);
    check("glitch_no_fe", fe0 - base, 0);
    send_frame(0, 8'h5A, 0, 1'b1);
    idle(5);
    check("post_glitch_byte", (got0.size() == 1) ? int'(got0[0]) : -1, 'h5A);
    got0.delete();

    // Framing error followed by a long break
    base = fe0;
    send_frame(0, 8'hFF, 0, 1'b0);
    idle(500);
    check("break_fe_once", fe0 - base, 1);
    check("break_no_byte", got0.size(), 0);
    check("break_busy", int'(busy0), 1);
    rx0 = 1'b1;
    idle(CPB);
    check("break_released", int'(busy0), 0);
    send_frame(0, 8'h01, 0, 1'b1);
    idle(5);
    check("post_break_byte", (got0.size() == 1) ? int'(got0[0]) : -1, 'h01);
    check("post_break_fe", fe0 - base, 1);
    got0.delete();

    // Overrun: holding register full, second frame dropped
    ready0 = 1'b0;
    base = ov0;
    send_frame(0, 8'h11, 0, 1'b1);
    send_frame(0, 8'h22, 0, 1'b1);
    check("ovr_valid", int'(valid0), 1);
    check("ovr_data_kept", int'(data0), 'h11);
    check("ovr_pulse", ov0 - base, 1);
    ready0 = 1'b1;
    idle(1);
    ready0 = 1'b0;
    idle(1);
    check("ovr_drain", (got0.size() == 1) ? int'(got0[0]) : -1, 'h11);
    check("ovr_cleared", int'(valid0), 0);
    got0.delete();

    // Same pair, with ready raised exactly in the completion cycle
    base = ov0;
    e0 = cyc + 1;
    send_frame(0, 8'h11, 0, 1'b1);
    fork
      send_frame(0, 8'h22, 0, 1'b1);
      begin
        wait_cyc(e0 + 10 * CPB + LAT - 1);
        ready0 = 1'b1;
        wait_cyc(e0 + 10 * CPB + LAT);
        ready0 = 1'b0;
      end
    join
    check("hs_data_new", int'(data0), 'h22);
    check("hs_valid", int'(valid0), 1);
    check("hs_no_ovr", ov0 - base, 0);
    ready0 = 1'b1;
    idle(2);
    check("hs_count", got0.size(), 2);
    check("hs_first", (got0.size() == 2) ? int'(got0[0]) : -1, 'h11);
    check("hs_second", (got0.size() == 2) ? int'(got0[1]) : -1, 'h22);
    got0.delete();

    // Parity receiver: good parity with latency, then bad parity
    e0 = cyc + 1;
    fork
      send_frame(1, 8'h07, 1, 1'b1);
      begin
        wait_cyc(e0 + LAT + CPB - 1);
        check("par_lat_before", int'(valid1), 0);
        wait_cyc(e0 + LAT + CPB);
        check("par_lat_rise", int'(valid1), 1);
        check("par_data", int'(data1), 'h07);
      end
    join
    base = pe1;
    send_frame(1, 8'h07, 2, 1'b1);
    idle(5);
    check("par_err_pulse", pe1 - base, 1);
    check("par_err_no_byte", got1.size(), 1);
    got1.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(1, b, 1, 1'b1);
    end
    idle(5);
    check("par_rand_count", got1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("par_rand_byte", (i < got1.size()) ? int'(got1[i]) : -1, int'(exp_q[i]));
    check("par_rand_errs", pe1 - base + fe1 + ov1, 1);
    exp_q.delete();

    // Random bytes with random idle gaps
    base = fe0 + pe0 + ov0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 4);
      exp_q.push_back(b);
      send_frame(0, b, 0, 1'b1);
      if (gap > 0) idle(gap);
    end
    idle(5);
    check("rand_count", got0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("rand_byte", (i < got0.size()) ? int'(got0[i]) : -1, int'(exp_q[i]));
    got0.delete();
    exp_q.delete();

    // All 256 values back-to-back
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      send_frame(0, 8'(v), 0, 1'b1);
    end
    idle(5);
    check("loop_count", got0.size(), 256);
    for (int i = 0; i < 256; i++)
      check("loop_byte", (i < got0.size()) ? int'(got0[i]) : -1, int'(exp_q[i]));
    check("loop_errs", fe0 + pe0 + ov0 - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Robust UART receiver with an internal bit timer, 3-sample majority voting, start-bit validation, optional even parity, and framing/parity/overrun detection. Frame format is 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit. It takes the serial line directly from the pin, or from uart_transmitter's uart_tx in loopback benches. Received bytes are delivered through a valid/ready holding register to the downstream consumer.

Parameters:
CLKS_PER_BIT, 20, clk cycles per bit; even, >=8; H = CLKS_PER_BIT/2
PARITY_EN, 0, 1 = an even-parity bit follows the data bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
uart_rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte; stable while rx_valid=1
rx_valid  output  1  byte available
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
frame_err  output  1  1-cycle pulse: stop bit sampled 0
parity_err  output  1  1-cycle pulse: parity mismatch (PARITY_EN=1 only)
overrun  output  1  1-cycle pulse: good byte dropped because the holding register was full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, both synchronizer flops=1, rx_data=0, rx_valid=0, all pulses=0, counters=0.
- uart_rx passes through a 2-flop synchronizer; rx_s is the second flop's output. All decisions use rx_s only.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP, WAIT_HIGH.
- Bit timer cnt: 0..CLKS_PER_BIT-1, reset to 0 on every state entry. Samples are taken at cnt=H-1, H and H+1. The majority value m is formed in the cnt=H+1 cycle from the two stored samples plus the current rx_s.
- IDLE: rx_s=0 -> START, cnt=0.
- START: at cnt=H+1, m=1 -> IDLE (glitch rejected, no output, no pulse). Otherwise, at cnt=CLKS_PER_BIT-1 -> DATA, bit_idx=0.
- DATA: at cnt=H+1, m shifts into the shift register, LSB first. At cnt=CLKS_PER_BIT-1: bit_idx=7 -> PARITY or STOP; else bit_idx+1.
- PARITY: at cnt=H+1, store m. At cnt=CLKS_PER_BIT-1 -> STOP.
- STOP: resolved at cnt=H+1. The stop bit is not waited out, which allows resync on back-to-back frames.
  - m=0 -> frame_err pulse, data discarded, -> WAIT_HIGH.
  - m=1 with XOR(data, parity)=1 -> parity_err pulse, data discarded, -> IDLE.
  - Otherwise the frame is good -> IDLE.
- WAIT_HIGH: stay until rx_s=1, then -> IDLE. This prevents break (line held low) from re-triggering frames.
- Good frame, output register update on the next edge:
  - rx_valid=0 -> rx_data=byte, rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle -> rx_data=new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0 -> old byte kept, overrun pulse.
- rx_valid clears on the edge after the cycle where rx_valid&&rx_ready, unless a simultaneous load occurs. rx_ready is ignored while rx_valid=0.
- Latency: let E0 be the first clk edge sampling uart_rx=0. rx_valid rises at edge E0 + 9*CLKS_PER_BIT + H + 4 (194 for defaults). Add CLKS_PER_BIT when PARITY_EN=1.
- Error pulses are registered and coincide with the edge where rx_valid would have risen.
- Frames may be back-to-back with no idle gap. Tolerance is ±(H-2) clocks of accumulated skew at the stop bit.

Test Plan:
- Reset mid-frame: assert rst_n low during DATA bit 3 -> all outputs 0 immediately, busy=0. After release, the next frame 0x3C is received correctly.
- Single frame 0xA5, CLKS_PER_BIT=20, rx_ready held 1 -> rx_valid rises exactly at E0+194, rx_data=0xA5, rx_valid high for exactly 1 cycle.
- Glitch: uart_rx low for 5 clocks only -> returns to IDLE, no rx_valid, no pulse. A following frame 0x5A is received correctly.
- Framing and break:
  - Frame 0xFF with stop=0, then line held low 500 clocks -> exactly one frame_err pulse, no rx_valid.
  - After the line returns high, frame 0x01 -> rx_data=0x01.
- Overrun and handshake:
  - rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data=0x11, one overrun pulse at the second frame's completion.
  - Repeat with rx_ready=1 exactly in the completion cycle -> rx_data=0x22, no overrun.
- Parity and loopback:
  - PARITY_EN=1: 0x07 with parity bit 1 -> valid. 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.
  - Loopback of all 256 byte values (0x00..0xFF) from uart_transmitter -> all received in order, zero errors.
